// File: rtl/lfsr_crypt_pkg.sv
// Shared types and helpers for the keyboard-data LFSR scrambler sequencer.
// Holds the controller state encoding, the default seed/tap constants and
// the pure LFSR next-state function used by both the core and the controller.
package lfsr_crypt_pkg;

   // Controller states: waiting for a word, stepping the keystream, presenting output.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      STEP = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
   localparam logic [15:0] DEFAULT_TAPS = 16'h002D;

   // Fibonacci step, right-shifting: feedback is the XOR of the tapped bits
   // and enters at the top of an n-bit register. Operands are zero-extended
   // to 64 bits so one function serves every width up to 64.
   function automatic logic [63:0] lfsr_next(input logic [63:0] q,
                                             input logic [63:0] taps,
                                             input int unsigned n);
      logic fb;
      fb = ^(q & taps);
      return (q >> 1) | ({63'd0, fb} << (n - 32'd1));
   endfunction

endpackage

// File: rtl/lfsr_crypt_ctrl_lfsr_core.sv
// Keystream LFSR register. A load from the seed path takes priority over a
// step so a rekey can never be lost to a concurrent advance.
module lfsr_core
   import lfsr_crypt_pkg::*;
#(
   parameter int             N    = 16,
   parameter logic [N-1:0]   TAPS = DEFAULT_TAPS,
   parameter logic [N-1:0]   SEED = DEFAULT_SEED
) (
   input  logic          clock,
   input  logic          n_reset,
   input  logic          step,
   input  logic          load,
   input  logic [N-1:0]  load_val,
   output logic [N-1:0]  q
);

   logic [N-1:0] q_r;
   logic [N-1:0] q_next_s;

   assign q_next_s = N'(lfsr_next(64'(q_r), 64'(TAPS), N));
   assign q        = q_r;

   // LFSR state: reload beats advance, otherwise hold.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         q_r <= SEED;
      end else if (load) begin
         q_r <= load_val;
      end else if (step) begin
         q_r <= q_next_s;
      end else begin
         q_r <= q_r;
      end
   end

endmodule

// File: rtl/lfsr_crypt_ctrl.sv
// Sequencer for the keyboard-data LFSR scrambler: accepts a keycode word,
// advances the keystream STEPS times, XORs, and hands the result downstream.
// Also owns the seed register, rekey sequencing and the delivered-word count.
// Build option: define LFSR_CRYPT_AUTO_REKEY_EN to request a rekey automatically
// every REKEY_INTERVAL delivered words.
module lfsr_crypt_ctrl
   import lfsr_crypt_pkg::*;
#(
   parameter int             N              = 16,
   parameter logic [N-1:0]   SEED           = DEFAULT_SEED,
   parameter logic [N-1:0]   TAPS           = DEFAULT_TAPS,
   parameter int             STEPS          = 1,
   parameter int             REKEY_INTERVAL = 256
) (
   input  logic          clock,
   input  logic          n_reset,
   input  logic [N-1:0]  in_data,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [N-1:0]  out_data,
   output logic          out_valid,
   input  logic          out_ready,
   input  logic [N-1:0]  seed_in,
   input  logic          seed_load,
   input  logic          rekey,
   output logic          busy,
   output logic [15:0]   word_count
);

`ifdef LFSR_CRYPT_AUTO_REKEY_EN
   localparam logic AUTO_EN = 1'b1;
`else
   localparam logic AUTO_EN = 1'b0;
`endif

   localparam logic [3:0]  STEP_LAST  = 4'(STEPS - 1);
   localparam logic [15:0] REKEY_LAST = 16'(REKEY_INTERVAL - 1);

   state_t        state_r;
   state_t        state_next_s;
   logic [N-1:0]  store_r;
   logic [N-1:0]  out_data_r;
   logic          out_valid_r;
   logic [15:0]   word_count_r;
   logic          rekey_pending_r;
   logic [3:0]    step_cnt_r;
   logic [N-1:0]  seed_r;

   logic [N-1:0]  lfsr_q_s;
   logic [N-1:0]  lfsr_next_s;
   logic          accept_s;
   logic          reload_s;
   logic          lfsr_step_s;
   logic          finish_s;
   logic          deliver_s;
   logic          auto_rekey_s;

   assign lfsr_next_s = N'(lfsr_next(64'(lfsr_q_s), 64'(TAPS), N));

   assign in_ready   = (state_r == IDLE) && !rekey_pending_r;
   assign busy       = (state_r != IDLE) || rekey_pending_r;
   assign out_data   = out_data_r;
   assign out_valid  = out_valid_r;
   assign word_count = word_count_r;

   lfsr_core #(
      .N    (N),
      .TAPS (TAPS),
      .SEED (SEED)
   ) u_lfsr_core (
      .clock    (clock),
      .n_reset  (n_reset),
      .step     (lfsr_step_s),
      .load     (reload_s),
      .load_val (seed_r),
      .q        (lfsr_q_s)
   );

   // State register.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state decode; a pending rekey keeps IDLE closed to new words.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid && !rekey_pending_r) begin
               state_next_s = STEP;
            end else begin
               state_next_s = IDLE;
            end
         end
         STEP: begin
            if (step_cnt_r == 4'd0) begin
               state_next_s = OUT;
            end else begin
               state_next_s = STEP;
            end
         end
         OUT: begin
            if (out_ready) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = OUT;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // Per-state control strobes driving the datapath and the LFSR core.
   always_comb begin
      accept_s     = 1'b0;
      reload_s     = 1'b0;
      lfsr_step_s  = 1'b0;
      finish_s     = 1'b0;
      deliver_s    = 1'b0;
      case (state_r)
         IDLE: begin
            accept_s = in_valid && !rekey_pending_r;
            reload_s = rekey_pending_r;
         end
         STEP: begin
            lfsr_step_s = 1'b1;
            finish_s    = (step_cnt_r == 4'd0);
         end
         OUT: begin
            deliver_s = out_ready;
         end
         default: begin
            accept_s = 1'b0;
         end
      endcase
      auto_rekey_s = AUTO_EN && deliver_s && (word_count_r == REKEY_LAST);
   end

   // Plaintext capture and step countdown.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         store_r    <= '0;
         step_cnt_r <= 4'd0;
      end else if (accept_s) begin
         store_r    <= in_data;
         step_cnt_r <= STEP_LAST;
      end else if (lfsr_step_s && (step_cnt_r != 4'd0)) begin
         store_r    <= store_r;
         step_cnt_r <= step_cnt_r - 4'd1;
      end else begin
         store_r    <= store_r;
         step_cnt_r <= step_cnt_r;
      end
   end

   // Output word register: XOR with the value the LFSR moves to on the last step.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         out_data_r  <= '0;
         out_valid_r <= 1'b0;
      end else if (finish_s) begin
         out_data_r  <= store_r ^ lfsr_next_s;
         out_valid_r <= 1'b1;
      end else if (deliver_s) begin
         out_data_r  <= out_data_r;
         out_valid_r <= 1'b0;
      end else begin
         out_data_r  <= out_data_r;
         out_valid_r <= out_valid_r;
      end
   end

   // Delivered-word counter: cleared by a reload, wraps naturally at 16 bits.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         word_count_r <= 16'd0;
      end else if (reload_s) begin
         word_count_r <= 16'd0;
      end else if (deliver_s) begin
         word_count_r <= word_count_r + 16'd1;
      end else begin
         word_count_r <= word_count_r;
      end
   end

   // Rekey request latch: a new request always wins over the clear.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         rekey_pending_r <= 1'b0;
      end else if (rekey || auto_rekey_s) begin
         rekey_pending_r <= 1'b1;
      end else if (reload_s) begin
         rekey_pending_r <= 1'b0;
      end else begin
         rekey_pending_r <= rekey_pending_r;
      end
   end

   // Seed register; an all-zero seed would lock the LFSR, so substitute SEED.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         seed_r <= SEED;
      end else if (seed_load) begin
         seed_r <= (seed_in == '0) ? SEED : seed_in;
      end else begin
         seed_r <= seed_r;
      end
   end

endmodule

// File: tb/tb_lfsr_crypt_ctrl.sv
// Directed bench for lfsr_crypt_ctrl (N=16, SEED=ACE1, TAPS=002D, STEPS=1).
// Keystream from ACE1: 5670, AB38, 559C -> words XOR 001C: 566C, AB24, 5580.
module tb_lfsr_crypt_ctrl;

`ifdef LFSR_CRYPT_AUTO_REKEY_EN
   localparam int RI = 2;
`else
   localparam int RI = 256;
`endif

   logic        clock = 1'b0;
   logic        n_reset;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] seed_in;
   logic        seed_load;
   logic        rekey;
   logic        busy;
   logic [15:0] word_count;

   int tests = 0;
   int fails = 0;

   always #5 clock = ~clock;

   lfsr_crypt_ctrl #(.REKEY_INTERVAL(RI)) dut (
      .clock      (clock),
      .n_reset    (n_reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .seed_in    (seed_in),
      .seed_load  (seed_load),
      .rekey      (rekey),
      .busy       (busy),
      .word_count (word_count)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present a word and wait (bounded) for the accepting edge.
   task automatic send(input logic [15:0] d);
      int n;
      n = 0;
      in_data  = d;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   // One full word with out_ready held high.
   task automatic xfer(input string tag, input logic [15:0] exp, input logic [15:0] exp_wc);
      send(16'h001C);
      tick();
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_data"}, {16'd0, out_data}, {16'd0, exp});
      tick();
      check({tag, "_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_wc"}, {16'd0, word_count}, {16'd0, exp_wc});
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_reset   = 1'b0;
      in_data   = 16'h0000;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      seed_in   = 16'h0000;
      seed_load = 1'b0;
      rekey     = 1'b0;
      #12;
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_data", {16'd0, out_data}, 32'h0000);
      check("rst_wc", {16'd0, word_count}, 32'd0);
      @(negedge clock);
      n_reset = 1'b1;
      tick();

      xfer("w1", 16'h566C, 16'd1);
      xfer("w2", 16'hAB24, 16'd2);

      // Manual rekey: one closed cycle, then reload from SEED.
      rekey = 1'b1;
      tick();
      rekey = 1'b0;
      check("rk_in_ready_lo", {31'd0, in_ready}, 32'd0);
      check("rk_busy", {31'd0, busy}, 32'd1);
      tick();
      check("rk_in_ready_hi", {31'd0, in_ready}, 32'd1);
      check("rk_wc_clear", {16'd0, word_count}, 32'd0);

      // Backpressure: output held while out_ready is low.
      out_ready = 1'b0;
      send(16'h001C);
      check("bp_in_ready_acc", {31'd0, in_ready}, 32'd0);
      tick();
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_data", {16'd0, out_data}, 32'h566C);
         check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         check("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
         check("bp_hold_busy", {31'd0, busy}, 32'd1);
      end
      out_ready = 1'b1;
      tick();
      check("bp_release_valid", {31'd0, out_valid}, 32'd0);
      check("bp_release_wc", {16'd0, word_count}, 32'd1);
      check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
      tick();
      check("bp_single_xfer", {16'd0, word_count}, 32'd1);

      // seed_load and rekey together: reload uses the new seed 5670.
      seed_in   = 16'h5670;
      seed_load = 1'b1;
      rekey     = 1'b1;
      tick();
      seed_load = 1'b0;
      rekey     = 1'b0;
      check("sr_in_ready_lo", {31'd0, in_ready}, 32'd0);
      tick();
      check("sr_in_ready_hi", {31'd0, in_ready}, 32'd1);
      xfer("seed_new", 16'hAB24, 16'd1);

      // Zero seed is replaced by SEED.
      seed_in   = 16'h0000;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      check("sz_in_ready", {31'd0, in_ready}, 32'd1);
      rekey = 1'b1;
      tick();
      rekey = 1'b0;
      tick();
      xfer("seed_zero", 16'h566C, 16'd1);

      // Reset while a word is held at the output.
      out_ready = 1'b0;
      send(16'h001C);
      tick();
      check("mr_valid_before", {31'd0, out_valid}, 32'd1);
      #2;
      n_reset = 1'b0;
      #1;
      check("mr_valid", {31'd0, out_valid}, 32'd0);
      check("mr_in_ready", {31'd0, in_ready}, 32'd1);
      check("mr_busy", {31'd0, busy}, 32'd0);
      check("mr_wc", {16'd0, word_count}, 32'd0);
      check("mr_data", {16'd0, out_data}, 32'h0000);
      @(negedge clock);
      n_reset   = 1'b1;
      out_ready = 1'b1;
      tick();

      // Three words after reset; the third shows whether auto-rekey fired.
      xfer("seq1", 16'h566C, 16'd1);
      xfer("seq2", 16'hAB24, 16'd2);
`ifdef LFSR_CRYPT_AUTO_REKEY_EN
      xfer("seq3", 16'h566C, 16'd1);
`else
      xfer("seq3", 16'h5580, 16'd3);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
